// File: rtl/shift_accumulator.sv
// Sums groups of aligned partial products from the shifter and
// emits one registered result per group over a valid/ready handshake.
module shift_accumulator #(
  parameter int IN_W  = 32,
  parameter int ACC_W = 36,
  parameter bit SAT   = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [IN_W-1:0]  in_data,
  input  logic             in_s,
  input  logic             in_valid,
  input  logic             in_last,
  output logic             in_ready,
  output logic [ACC_W-1:0] out_data,
  output logic             out_ovf,
  output logic             out_valid,
  input  logic             out_ready
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACC,
    S_DONE
  } state_t;

  localparam logic [ACC_W-1:0] S_MAX =
    {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] S_MIN = ~S_MAX;
  localparam logic [ACC_W-1:0] U_MAX = '1;

  state_t           r_state;
  state_t           w_state_nx;
  logic [ACC_W-1:0] r_acc;
  logic [ACC_W-1:0] w_acc_nx;
  logic             r_sign;
  logic             w_sign_nx;
  logic             r_ovf;
  logic             w_ovf_nx;

  logic             w_accept;
  logic             w_first;
  logic             w_sgn;
  logic             w_xbit;
  logic [ACC_W-1:0] w_ext;
  logic [ACC_W:0]   w_sum;
  logic             w_add_ovf;
  logic [ACC_W-1:0] w_sat_val;
  logic [ACC_W-1:0] w_add_res;

  assign in_ready  = (r_state != S_DONE) || out_ready;
  assign out_valid = (r_state == S_DONE);
  assign out_data  = r_acc;
  assign out_ovf   = r_ovf;

  assign w_accept = in_valid && in_ready;
  // Any beat not landing in ACC starts a new group and uses in_s.
  assign w_first  = (r_state != S_ACC);
  assign w_sgn    = w_first ? in_s : r_sign;
  assign w_xbit   = w_sgn & in_data[IN_W-1];

  generate
    if (ACC_W > IN_W) begin : g_ext
      assign w_ext = {{(ACC_W-IN_W){w_xbit}}, in_data};
    end else begin : g_noext
      assign w_ext = in_data;
    end
  endgenerate

  assign w_sum = {1'b0, r_acc} + {1'b0, w_ext};

  always_comb begin
    w_add_ovf = 1'b0;
    w_sat_val = U_MAX;
    if (r_sign) begin
      w_add_ovf = (r_acc[ACC_W-1] == w_ext[ACC_W-1]) &&
                  (w_sum[ACC_W-1] != r_acc[ACC_W-1]);
      w_sat_val = r_acc[ACC_W-1] ? S_MIN : S_MAX;
    end else begin
      w_add_ovf = w_sum[ACC_W];
    end
    w_add_res = w_sum[ACC_W-1:0];
    if (SAT && w_add_ovf) begin
      w_add_res = w_sat_val;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_acc_nx   = r_acc;
    w_sign_nx  = r_sign;
    w_ovf_nx   = r_ovf;
    unique case (r_state)
      S_IDLE, S_DONE: begin
        if (r_state == S_DONE && out_ready) begin
          w_state_nx = S_IDLE;
        end
        if (w_accept) begin
          w_acc_nx   = w_ext;
          w_sign_nx  = in_s;
          w_ovf_nx   = 1'b0;
          w_state_nx = in_last ? S_DONE : S_ACC;
        end
      end
      S_ACC: begin
        if (w_accept) begin
          w_acc_nx   = w_add_res;
          w_ovf_nx   = r_ovf | w_add_ovf;
          w_state_nx = in_last ? S_DONE : S_ACC;
        end
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_acc   <= '0;
      r_sign  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_acc   <= w_acc_nx;
      r_sign  <= w_sign_nx;
      r_ovf   <= w_ovf_nx;
    end
  end

endmodule

// File: tb/tb_shift_accumulator.sv
// Directed bench: default instance plus 33-bit saturating and
// wrapping instances sharing the same input stimulus.
module tb_shift_accumulator;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] in_data = '0;
  logic        in_s = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_last = 1'b0;
  logic        out_ready = 1'b0;

  logic        rdy_d, val_d, ovf_d;
  logic [35:0] dat_d;
  logic        rdy_s, val_s, ovf_s;
  logic [32:0] dat_s;
  logic        rdy_w, val_w, ovf_w;
  logic [32:0] dat_w;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  shift_accumulator u_def (
    .clk(clk), .reset(reset), .in_data(in_data),
    .in_s(in_s), .in_valid(in_valid), .in_last(in_last),
    .in_ready(rdy_d), .out_data(dat_d), .out_ovf(ovf_d),
    .out_valid(val_d), .out_ready(out_ready)
  );

  shift_accumulator #(.IN_W(32), .ACC_W(33), .SAT(1'b1)) u_sat (
    .clk(clk), .reset(reset), .in_data(in_data),
    .in_s(in_s), .in_valid(in_valid), .in_last(in_last),
    .in_ready(rdy_s), .out_data(dat_s), .out_ovf(ovf_s),
    .out_valid(val_s), .out_ready(out_ready)
  );

  shift_accumulator #(.IN_W(32), .ACC_W(33), .SAT(1'b0)) u_wrp (
    .clk(clk), .reset(reset), .in_data(in_data),
    .in_s(in_s), .in_valid(in_valid), .in_last(in_last),
    .in_ready(rdy_w), .out_data(dat_w), .out_ovf(ovf_w),
    .out_valid(val_w), .out_ready(out_ready)
  );

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [31:0] d, input logic s,
                      input logic last);
    in_valid = 1'b1;
    in_data  = d;
    in_s     = s;
    in_last  = last;
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    tick();
    tick();
    chk("rst_valid", 64'(val_d), 64'd0);
    chk("rst_data", 64'(dat_d), 64'd0);
    chk("rst_ovf", 64'(ovf_d), 64'd0);
    reset = 1'b0;
    tick();
    chk("rst_ready", 64'(rdy_d), 64'd1);

    // single beat
    beat(32'h5, 1'b0, 1'b1);
    chk("one_valid", 64'(val_d), 64'd1);
    chk("one_data", 64'(dat_d), 64'h5);
    chk("one_ovf", 64'(ovf_d), 64'd0);
    out_ready = 1'b1;
    tick();
    chk("one_drop", 64'(val_d), 64'd0);

    // four beats with ready held high
    for (int i = 1; i <= 4; i++) begin
      chk($sformatf("four_rdy%0d", i), 64'(rdy_d), 64'd1);
      chk($sformatf("four_nv%0d", i), 64'(val_d), 64'd0);
      beat(32'(i), 1'b0, i == 4);
    end
    chk("four_valid", 64'(val_d), 64'd1);
    chk("four_data", 64'(dat_d), 64'hA);
    chk("four_rdy", 64'(rdy_d), 64'd1);
    tick();
    chk("four_drop", 64'(val_d), 64'd0);

    // signed group, then backpressure
    out_ready = 1'b0;
    beat(32'hFFFF_FFFF, 1'b1, 1'b0);
    beat(32'hFFFF_FFFE, 1'b0, 1'b1);
    chk("sgn_valid", 64'(val_d), 64'd1);
    chk("sgn_data", 64'(dat_d), 64'hF_FFFF_FFFD);
    chk("sgn_ovf", 64'(ovf_d), 64'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("bp_valid%0d", i), 64'(val_d), 64'd1);
      chk($sformatf("bp_data%0d", i), 64'(dat_d),
          64'hF_FFFF_FFFD);
      chk($sformatf("bp_ready%0d", i), 64'(rdy_d), 64'd0);
    end
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 32'h7;
    in_s      = 1'b0;
    in_last   = 1'b1;
    #1;
    chk("b2b_ready", 64'(rdy_d), 64'd1);
    tick();
    in_valid = 1'b0;
    chk("b2b_valid", 64'(val_d), 64'd1);
    chk("b2b_data", 64'(dat_d), 64'h7);
    tick();
    chk("b2b_drop", 64'(val_d), 64'd0);

    // unsigned overflow on the 33-bit instances
    out_ready = 1'b0;
    beat(32'hFFFF_FFFF, 1'b0, 1'b0);
    beat(32'hFFFF_FFFF, 1'b0, 1'b0);
    beat(32'hFFFF_FFFF, 1'b0, 1'b1);
    chk("uov_sat_data", 64'(dat_s), 64'h1_FFFF_FFFF);
    chk("uov_sat_ovf", 64'(ovf_s), 64'd1);
    chk("uov_wrp_data", 64'(dat_w), 64'h0_FFFF_FFFD);
    chk("uov_wrp_ovf", 64'(ovf_w), 64'd1);
    chk("uov_def_data", 64'(dat_d), 64'h2_FFFF_FFFD);
    chk("uov_def_ovf", 64'(ovf_d), 64'd0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // signed overflow, sticky flag, add onto clamped value
    beat(32'h8000_0000, 1'b1, 1'b0);
    beat(32'h8000_0000, 1'b0, 1'b0);
    beat(32'h8000_0000, 1'b0, 1'b0);
    beat(32'h0000_0001, 1'b0, 1'b1);
    chk("sov_sat_data", 64'(dat_s), 64'h1_0000_0001);
    chk("sov_sat_ovf", 64'(ovf_s), 64'd1);
    chk("sov_wrp_data", 64'(dat_w), 64'h0_8000_0001);
    chk("sov_wrp_ovf", 64'(ovf_w), 64'd1);
    chk("sov_def_data", 64'(dat_d), 64'hE_8000_0001);
    chk("sov_def_ovf", 64'(ovf_d), 64'd0);
    out_ready = 1'b1;
    tick();

    // reset mid-group
    beat(32'h1, 1'b0, 1'b0);
    beat(32'h2, 1'b0, 1'b0);
    chk("mid_acc", 64'(dat_d), 64'h3);
    #2;
    reset = 1'b1;
    #1;
    chk("mid_valid", 64'(val_d), 64'd0);
    chk("mid_data", 64'(dat_d), 64'd0);
    chk("mid_ovf", 64'(ovf_d), 64'd0);
    tick();
    reset = 1'b0;
    tick();
    chk("mid_ready", 64'(rdy_d), 64'd1);
    out_ready = 1'b0;
    beat(32'h9, 1'b0, 1'b1);
    chk("post_valid", 64'(val_d), 64'd1);
    chk("post_data", 64'(dat_d), 64'h9);
    out_ready = 1'b1;
    tick();
    chk("post_drop", 64'(val_d), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
